// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC frame serializer.
package crc_pkg;

    // Frame-level controller states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SHIFT  = 3'd2,
        HOLD   = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    // In CRC-8 mode only the low byte of the engine result is meaningful
    localparam logic [15:0] CRC8_MASK = 16'h00FF;

    localparam logic CRC_MODE_8  = 1'b0;
    localparam logic CRC_MODE_16 = 1'b1;

    // Word counter increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/word_shifter.sv
// Loadable MSB-first shift register with a bit counter that flags the
// final bit of the word currently being shifted out.
module word_shifter #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift_en,
    output logic              ser_bit,
    output logic              last_bit
);

    localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign ser_bit  = shreg_q[WORD_W-1];
    assign last_bit = (cnt_q == CNT_LAST);

    // Load takes priority so a new word can replace the last bit with no bubble
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = '0;
        end else if (shift_en) begin
            shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
        end
    end

    // Shift register and bit counter storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/crc_frame_serializer.sv
// Frame front-end for a bit-serial CRC engine: accepts words on a
// valid/ready stream, initialises the engine, serialises each word
// MSB-first and captures the engine result at the end of the frame.
module crc_frame_serializer
    import crc_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CRC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              cfg_mode,
    input  logic [CRC_W-1:0]  cfg_poly,
    output logic              crc_init,
    output logic              ser_data,
    output logic              ser_valid,
    output logic              crc_mode,
    output logic [CRC_W-1:0]  polynomial,
    input  logic [CRC_W-1:0]  crc_in,
    output logic [CRC_W-1:0]  frame_crc,
    output logic              frame_crc_valid,
    output logic [15:0]       frame_words,
    output logic              busy
);

    localparam logic [CRC_W-1:0] MASK8 = CRC_W'(CRC8_MASK);

    state_t            state_q, state_d;
    logic              last_word_q, last_word_d;
    logic              mode_q, mode_d;
    logic [CRC_W-1:0]  poly_q, poly_d;
    logic [15:0]       count_q, count_d;
    logic [CRC_W-1:0]  frame_crc_q, frame_crc_d;
    logic [15:0]       frame_words_q, frame_words_d;

    logic              load;
    logic              shift_en;
    logic              ready_int;
    logic              sh_bit;
    logic              sh_last_bit;

    word_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (s_data),
        .shift_en  (shift_en),
        .ser_bit   (sh_bit),
        .last_bit  (sh_last_bit)
    );

    // Next-state, handshake and capture decisions for the frame controller
    always_comb begin
        state_d       = state_q;
        last_word_d   = last_word_q;
        mode_d        = mode_q;
        poly_d        = poly_q;
        count_d       = count_q;
        frame_crc_d   = frame_crc_q;
        frame_words_d = frame_words_q;
        load          = 1'b0;
        shift_en      = 1'b0;
        ready_int     = 1'b0;

        case (state_q)
            IDLE: begin
                ready_int = 1'b1;
                if (s_valid) begin
                    load        = 1'b1;
                    mode_d      = cfg_mode;
                    poly_d      = cfg_poly;
                    count_d     = 16'd1;
                    last_word_d = s_last;
                    state_d     = INIT;
                end
            end
            INIT: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (sh_last_bit) begin
                    if (last_word_q) begin
                        state_d = SETTLE;
                    end else begin
                        // Next word may arrive on the final bit for gapless output
                        ready_int = 1'b1;
                        if (s_valid) begin
                            load        = 1'b1;
                            count_d     = sat_inc16(count_q);
                            last_word_d = s_last;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                ready_int = 1'b1;
                if (s_valid) begin
                    load        = 1'b1;
                    count_d     = sat_inc16(count_q);
                    last_word_d = s_last;
                    state_d     = SHIFT;
                end
            end
            SETTLE: begin
                // Engine has absorbed the final bit by now; capture its result
                frame_crc_d   = (mode_q == CRC_MODE_16) ? crc_in : (crc_in & MASK8);
                frame_words_d = count_q;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and per-frame registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_word_q   <= 1'b0;
            mode_q        <= 1'b0;
            poly_q        <= '0;
            count_q       <= '0;
            frame_crc_q   <= '0;
            frame_words_q <= '0;
        end else begin
            state_q       <= state_d;
            last_word_q   <= last_word_d;
            mode_q        <= mode_d;
            poly_q        <= poly_d;
            count_q       <= count_d;
            frame_crc_q   <= frame_crc_d;
            frame_words_q <= frame_words_d;
        end
    end

    // Ready is masked by reset so it stays low while the reset input is held
    assign s_ready         = ready_int & ~rst;
    assign crc_init        = (state_q == INIT);
    assign ser_valid       = (state_q == SHIFT);
    assign ser_data        = ser_valid & sh_bit;
    assign frame_crc_valid = (state_q == DONE);
    assign busy            = (state_q != IDLE);
    assign crc_mode        = mode_q;
    assign polynomial      = poly_q;
    assign frame_crc       = frame_crc_q;
    assign frame_words     = frame_words_q;

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed bench for crc_frame_serializer with a behavioural bit-serial
// CRC engine (or a constant stub) attached to crc_in.
module tb_crc_frame_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        cfg_mode = 1'b0;
    logic [15:0] cfg_poly = 16'h0;
    logic        crc_init;
    logic        ser_data;
    logic        ser_valid;
    logic        crc_mode;
    logic [15:0] polynomial;
    logic [15:0] crc_in;
    logic [15:0] frame_crc;
    logic        frame_crc_valid;
    logic [15:0] frame_words;
    logic        busy;

    logic        stub_en = 1'b0;
    logic [15:0] eng_q = 16'h5A5A;

    int n_checks = 0;
    int n_fail   = 0;

    crc_frame_serializer #(
        .WORD_W (32),
        .CRC_W  (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_last          (s_last),
        .s_ready         (s_ready),
        .cfg_mode        (cfg_mode),
        .cfg_poly        (cfg_poly),
        .crc_init        (crc_init),
        .ser_data        (ser_data),
        .ser_valid       (ser_valid),
        .crc_mode        (crc_mode),
        .polynomial      (polynomial),
        .crc_in          (crc_in),
        .frame_crc       (frame_crc),
        .frame_crc_valid (frame_crc_valid),
        .frame_words     (frame_words),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // One step of an MSB-first LFSR CRC with zero initial value
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b,
                                             input logic mode, input logic [15:0] poly);
        logic        fb;
        logic [15:0] n;
        fb = (mode ? c[15] : c[7]) ^ b;
        n  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0);
        if (!mode) n = n & 16'h00FF;
        return n;
    endfunction

    function automatic logic [15:0] crc_model(input logic [63:0] bits, input int nb,
                                              input logic mode, input logic [15:0] poly);
        logic [15:0] c;
        c = 16'h0;
        for (int i = nb - 1; i >= 0; i--) c = crc_step(c, bits[i], mode, poly);
        return c;
    endfunction

    // Stand-in engine: not reset by rst, only by crc_init
    always @(posedge clk) begin
        if (crc_init) eng_q <= 16'h0;
        else if (ser_valid) eng_q <= crc_step(eng_q, ser_data, crc_mode, polynomial);
    end
    assign crc_in = stub_en ? 16'hABCD : eng_q;

    // Cycle counter and output monitor
    int          cyc = 0;
    int          n_init = 0, n_ser = 0, n_rise = 0, n_done = 0;
    int          init_cyc = 0, last_ser_cyc = 0;
    logic        prev_sv = 1'b0;
    logic [63:0] cap = 64'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (crc_init) begin
            n_init++;
            init_cyc = cyc;
        end
        if (ser_valid) begin
            n_ser++;
            cap = {cap[62:0], ser_data};
            if (!prev_sv) n_rise++;
            last_ser_cyc = cyc;
        end
        prev_sv = ser_valid;
        if (frame_crc_valid) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, 64'(s_ready), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({s_ready, ser_valid, ser_data, crc_init, busy,
                                  frame_crc_valid, crc_mode}), 64'd0);
        check({tag, "_poly"}, 64'(polynomial), 64'd0);
        check({tag, "_crc"}, 64'(frame_crc), 64'd0);
        check({tag, "_words"}, 64'(frame_words), 64'd0);
    endtask

    // One complete frame of one or two words; gap = idle cycles before word 2
    task automatic run_frame(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                             input int nw, input logic mode, input logic [15:0] poly,
                             input int gap, input logic use_stub);
        int          acc, nb, s_init, s_ser, s_rise, s_done, n;
        logic [63:0] exp_bits;
        logic [15:0] exp_crc;

        nb       = 32 * nw;
        exp_bits = (nw == 1) ? {32'h0, w0} : {w0, w1};
        if (use_stub) exp_crc = mode ? 16'hABCD : 16'h00CD;
        else          exp_crc = crc_model(exp_bits, nb, mode, poly);

        wait_ready(tag);
        s_valid  = 1'b1;
        s_data   = w0;
        s_last   = (nw == 1);
        cfg_mode = mode;
        cfg_poly = poly;
        acc      = cyc;
        s_init   = n_init;
        s_ser    = n_ser;
        s_rise   = n_rise;
        s_done   = n_done;
        tick();
        check({tag, "_init_pulse"}, 64'(crc_init), 64'd1);
        check({tag, "_ready_in_init"}, 64'(s_ready), 64'd0);
        check({tag, "_poly_latched"}, 64'(polynomial), 64'(poly));

        if (nw == 2 && gap == 0) begin
            s_data = w1;
            s_last = 1'b1;
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = 32'hDEADBEEF;
        end
        // Configuration changes after the first word must not reach the outputs
        cfg_poly = 16'h001D;
        cfg_mode = ~mode;

        for (int i = 0; i < 32; i++) tick();
        check({tag, "_ready_last_bit"}, 64'(s_ready), 64'(nw == 2));
        check({tag, "_poly_hold"}, 64'(polynomial), 64'(poly));
        check({tag, "_mode_hold"}, 64'(crc_mode), 64'(mode));

        if (nw == 2) begin
            tick();
            if (gap > 0) begin
                for (int g = 0; g < gap; g++) begin
                    check({tag, "_hold_ser_valid"}, 64'(ser_valid), 64'd0);
                    check({tag, "_hold_ready"}, 64'(s_ready), 64'd1);
                    if (g == gap - 1) begin
                        s_valid = 1'b1;
                        s_data  = w1;
                        s_last  = 1'b1;
                    end
                    tick();
                end
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = 32'hDEADBEEF;
        end

        n = 0;
        while (frame_crc_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_done_strobe"}, 64'(frame_crc_valid), 64'd1);
        check({tag, "_init_cyc"}, 64'(init_cyc), 64'(acc + 1));
        check({tag, "_last_bit_cyc"}, 64'(last_ser_cyc), 64'(acc + 1 + nb + gap));
        check({tag, "_done_cyc"}, 64'(cyc), 64'(last_ser_cyc + 2));
        check({tag, "_init_count"}, 64'(n_init - s_init), 64'd1);
        check({tag, "_ser_count"}, 64'(n_ser - s_ser), 64'(nb));
        check({tag, "_ser_bursts"}, 64'(n_rise - s_rise), 64'((gap > 0) ? 2 : 1));
        check({tag, "_ser_bits"}, (nw == 1) ? {32'h0, cap[31:0]} : cap, exp_bits);
        check({tag, "_frame_crc"}, 64'(frame_crc), 64'(exp_crc));
        check({tag, "_frame_words"}, 64'(frame_words), 64'(nw));
        tick();
        check({tag, "_ready_idle"}, 64'(s_ready), 64'd1);
        check({tag, "_strobe_one_cycle"}, 64'(n_done - s_done), 64'd1);
        check({tag, "_busy_idle"}, 64'(busy), 64'd0);
        $display("frame %s: words=%0d mode=%0d poly=%04h crc=%04h (expected %04h)",
                 tag, frame_words, mode, poly, frame_crc, exp_crc);
    endtask

    initial begin
        int s_done;

        // Outputs are all zero while reset is held
        #3;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(s_ready), 64'd1);

        run_frame("single_crc8", 32'h12345678, 32'h0, 1, 1'b0, 16'h0007, 0, 1'b0);
        run_frame("b2b_crc16", 32'h11223344, 32'h55667788, 2, 1'b1, 16'h8005, 0, 1'b0);
        run_frame("gap_crc16", 32'h11223344, 32'h55667788, 2, 1'b1, 16'h8005, 5, 1'b0);
        check("gap_same_crc", 64'(frame_crc),
              64'(crc_model({32'h11223344, 32'h55667788}, 64, 1'b1, 16'h8005)));

        stub_en = 1'b1;
        run_frame("stub_crc8", 32'hCAFEF00D, 32'h0, 1, 1'b0, 16'h001D, 0, 1'b1);
        run_frame("stub_crc16", 32'h0BADF00D, 32'h0, 1, 1'b1, 16'h1021, 0, 1'b1);
        stub_en = 1'b0;

        // Reset in the middle of the second word of a frame
        wait_ready("rst_mid");
        s_valid  = 1'b1;
        s_data   = 32'hA5A5A5A5;
        s_last   = 1'b0;
        cfg_mode = 1'b1;
        cfg_poly = 16'h8005;
        tick();
        s_data = 32'h3C3C3C3C;
        s_last = 1'b1;
        for (int i = 0; i < 33; i++) tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rst_mid_shifting", 64'(ser_valid), 64'd1);
        s_done = n_done;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_async");
        tick();
        tick();
        check_all_zero("rst_mid_held");
        rst = 1'b0;
        #1;
        check("rst_mid_ready_release", 64'(s_ready), 64'd1);
        for (int i = 0; i < 40; i++) tick();
        check("rst_mid_no_strobe", 64'(n_done - s_done), 64'd0);

        run_frame("after_rst", 32'hF00DFACE, 32'h0, 1, 1'b1, 16'h1021, 0, 1'b0);
        run_frame("after_rst2", 32'h0F0F1234, 32'h89ABCDEF, 2, 1'b0, 16'h0007, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/crc_frame_serializer.md
# crc_frame_serializer

Upstream feeder for `serial_crc`. Accepts 32-bit words per frame over a valid/ready stream and latches the CRC mode/polynomial at frame start. Pulses the engine's init, then shifts every word out MSB-first, one bit per cycle. After the last bit it samples the engine's result and presents it as a one-cycle `frame_crc_valid` strobe with a word count.

## Interface
- `WORD_W`, 32: input word width; bits serialized per word.
- `CRC_W`, 16: width of `crc_in` / `frame_crc` / `polynomial`.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, asynchronous, active-high; all state cleared immediately.
- `s_data` in WORD_W: input word.
- `s_valid` in 1: `s_data` / `s_last` valid.
- `s_last` in 1: this word ends the frame.
- `s_ready` out 1: block accepts a word this cycle (transfer = `s_valid & s_ready`).
- `cfg_mode` in 1: 0 = CRC-8, 1 = CRC-16; sampled on the first word of a frame.
- `cfg_poly` in CRC_W: polynomial; sampled with `cfg_mode`.
- `crc_init` out 1: one-cycle init pulse to the engine.
- `ser_data` out 1: serial bit to the engine.
- `ser_valid` out 1: `ser_data` valid.
- `crc_mode` out 1: latched `cfg_mode`, held for the whole frame.
- `polynomial` out CRC_W: latched `cfg_poly`, held for the whole frame.
- `crc_in` in CRC_W: engine result (`crc_out`).
- `frame_crc` out CRC_W: captured CRC; upper 8 bits forced to 0 in CRC-8 mode.
- `frame_crc_valid` out 1: one-cycle strobe when `frame_crc` updates.
- `frame_words` out 16: words in the completed frame, saturating at 0xFFFF.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: `s_ready`=1. On a transfer: load the shift register, latch cfg, set word count to 1, go to INIT.
  - INIT: `crc_init`=1 for exactly one cycle, then go to SHIFT.
  - SHIFT: `ser_valid`=1, `ser_data`=shreg[WORD_W-1]; shift left each cycle; bit counter counts 0..WORD_W-1.
  - On bit WORD_W-1 of a non-last word: `s_ready`=1.
    - Transfer: reload, count+1, stay in SHIFT with no bubble.
    - No transfer: go to HOLD.
  - On bit WORD_W-1 of the last word: go to SETTLE; `s_ready`=0.
  - HOLD: `ser_valid`=0, `s_ready`=1; on a transfer, load and go to SHIFT.
  - SETTLE: one cycle for the engine to absorb the last bit. `crc_in` is sampled at the end of this cycle into `frame_crc` (masked per mode) and `frame_words`, then go to DONE.
  - DONE: `frame_crc_valid`=1 for one cycle, then go to IDLE.
- A single-word frame has `s_last`=1 on the word accepted in IDLE.
- `s_last` is tracked per word; `s_last` is ignored when `s_valid`=0.
- `cfg_*` changes after the first word have no effect until the next frame.
- Word count increments on each accepted word and holds at 0xFFFF.
- `s_ready` is 0 in INIT, SETTLE and DONE, and in SHIFT except on bit WORD_W-1 of a non-last word.

## Timing
- Reset values:
  - All outputs 0, including `s_ready`, `frame_crc`, `frame_words`, `crc_mode` and `polynomial`.
  - State IDLE, so `s_ready` rises in the first cycle after `rst` falls.
- Relative to a first word accepted at edge T:
  - `crc_init` is high in cycle T+1.
  - Bits appear in cycles T+2 .. T+1+WORD_W.
- For a last bit presented in cycle L:
  - SETTLE occupies L+1.
  - `frame_crc_valid` is high in L+2.
  - `s_ready`=1 again in L+3, in IDLE.
- Back-to-back words inside a frame give continuous `ser_valid` with no gap.
- `rst` asserted mid-frame:
  - All outputs drop immediately, with no `frame_crc_valid`.
  - The engine is re-initialized by the next frame's `crc_init`.

## Structure
- Shared package `crc_pkg`:
  - state enum (IDLE, INIT, SHIFT, HOLD, SETTLE, DONE);
  - `CRC8_MASK` = 16'h00FF;
  - mode constants `CRC_MODE_8` = 0 and `CRC_MODE_16` = 1.
- One natural sub-module: `word_shifter`, a loadable MSB-first shift register with bit counter and `last_bit` flag. FSM and capture logic stay in the top.

## Test plan
- Single word 0x12345678, `s_last`=1, mode 0, poly 0x07, real `serial_crc` attached:
  - `crc_init` in T+1;
  - `ser_data` sequence 0,0,0,1,0,0,1,0,… over 32 continuous cycles;
  - `frame_crc_valid` 2 cycles after the last bit;
  - `frame_crc` equals the bench bit-serial model, bits [15:8] = 0;
  - `frame_words` = 1.
- Two words 0x11223344 then 0x55667788, mode 1, poly 0x8005, `s_valid` held high:
  - 64 consecutive `ser_valid` cycles with no gap, a single `crc_init`;
  - `frame_words` = 2;
  - `frame_crc` matches the model.
- Same two words with second-word `s_valid` delayed 5 cycles:
  - HOLD for 5 cycles with `ser_valid`=0 and `s_ready`=1;
  - same `frame_crc` as the back-to-back case.
- Stub engine driving `crc_in` = 0xABCD:
  - mode 0 gives `frame_crc` = 0x00CD;
  - mode 1 gives 0xABCD.
- `cfg_poly` changed from 0x0007 to 0x001D after the first word of a frame: `polynomial` output stays 0x0007 until the next frame.
- `rst` pulsed in the middle of the 2nd word:
  - all outputs 0 during reset;
  - no `frame_crc_valid`;
  - `s_ready`=1 in the first cycle after release;
  - the next frame completes correctly.
